// File: rtl/mac_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mac_seq_ctrl
//   Control FSM for the gate-level multiply-accumulate datapath.
//   Each 4x4 multiply is built from four 2x2 partial products. The high
//   halves go first so the partial register can be shifted left by 2 between
//   the two passes:
//       partial = 16*hh + 4*hl + 4*lh + ll
//   N_TERMS products are summed into the accumulator per MAC operation.
//   Operands are accepted on in_valid/in_ready and the result is handed off
//   on out_valid/out_ready.
//
//   Optional build macro: MAC_SEQ_CTRL_PERF_EN
//     When defined, the perf_cycles[15:0] output is added. It counts the
//     cycles spent in WAIT_OP, MUL0-3 and ACC, saturates at 16'hFFFF and is
//     cleared on reset and on the start-accept cycle. When the macro is not
//     defined, both the port and the counter are absent.
// ---------------------------------------------------------------------------
module mac_seq_ctrl #(
    parameter int N_TERMS = 4,   // legal range 1..7
    parameter int CNT_W   = 3    // 2**CNT_W must exceed N_TERMS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             busy,
    output logic             ld_in,
    output logic             prod_clr,
    output logic             prod_ld,
    output logic             sela,
    output logic             selb,
    output logic             psh,
    output logic             acc_clr,
    output logic             acc_ld,
    output logic [CNT_W-1:0] term_cnt
`ifdef MAC_SEQ_CTRL_PERF_EN
    ,
    output logic [15:0]      perf_cycles
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_OP = 3'd1,
        MUL0    = 3'd2,
        MUL1    = 3'd3,
        MUL2    = 3'd4,
        MUL3    = 3'd5,
        ACC     = 3'd6,
        DONE    = 3'd7
    } state_t;

    // Counter value at which the ACC state completes the final term.
    localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(N_TERMS - 1);

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] term_cnt_r;
    logic             start_accept_s;

    // Partial-product step table {sela, selb, psh}. The high halves are taken
    // first; the shift is applied on the second pass of each A half so that
    // hh ends up weighted by 16 and the cross terms by 4.
    function automatic logic [2:0] mul_step(input state_t st);
        logic [2:0] code;
        case (st)
            MUL0:    code = 3'b110;  // hh
            MUL1:    code = 3'b101;  // hl, shifts hh left by 2
            MUL2:    code = 3'b010;  // lh
            MUL3:    code = 3'b001;  // ll, shifts the running sum left by 2
            default: code = 3'b000;
        endcase
        return code;
    endfunction

    // Reset takes priority over start, so a start raised together with reset
    // is not accepted.
    assign start_accept_s = (state_r == IDLE) && start && !rst;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = WAIT_OP;
                end else begin
                    next_state_s = IDLE;
                end
            end
            WAIT_OP: begin
                if (in_valid) begin
                    next_state_s = MUL0;
                end else begin
                    next_state_s = WAIT_OP;
                end
            end
            MUL0:    next_state_s = MUL1;
            MUL1:    next_state_s = MUL2;
            MUL2:    next_state_s = MUL3;
            MUL3:    next_state_s = ACC;
            ACC: begin
                if (term_cnt_r == LAST_TERM) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = WAIT_OP;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Output decode. Outputs are Moore, except that acc_clr, ld_in and
    // prod_clr also depend on the handshake input of the current cycle.
    // Those three are suppressed while rst is high so that reset wins.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        ld_in     = 1'b0;
        prod_clr  = 1'b0;
        prod_ld   = 1'b0;
        sela      = 1'b0;
        selb      = 1'b0;
        psh       = 1'b0;
        acc_clr   = 1'b0;
        acc_ld    = 1'b0;
        case (state_r)
            IDLE: begin
                acc_clr = start_accept_s;
            end
            WAIT_OP: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid && !rst) begin
                    ld_in    = 1'b1;
                    prod_clr = 1'b1;
                end else begin
                    ld_in    = 1'b0;
                    prod_clr = 1'b0;
                end
            end
            MUL0, MUL1, MUL2, MUL3: begin
                busy               = 1'b1;
                prod_ld            = 1'b1;
                {sela, selb, psh}  = mul_step(state_r);
            end
            ACC: begin
                busy   = 1'b1;
                acc_ld = 1'b1;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Term counter: cleared at start-accept and at result hand-off, and
    // advanced once per accumulated product.
    always_ff @(posedge clk) begin
        if (rst) begin
            term_cnt_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        term_cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        term_cnt_r <= term_cnt_r;
                    end
                end
                ACC: begin
                    term_cnt_r <= term_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                DONE: begin
                    if (out_ready) begin
                        term_cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        term_cnt_r <= term_cnt_r;
                    end
                end
                default: begin
                    term_cnt_r <= term_cnt_r;
                end
            endcase
        end
    end

    assign term_cnt = term_cnt_r;

`ifdef MAC_SEQ_CTRL_PERF_EN
    logic [15:0] perf_cycles_r;
    logic        perf_active_s;

    // The counter runs only while an operation is actively being worked on.
    // It is frozen while the result waits in DONE and while the FSM is IDLE.
    assign perf_active_s = (state_r == WAIT_OP) || (state_r == MUL0) ||
                           (state_r == MUL1)    || (state_r == MUL2) ||
                           (state_r == MUL3)    || (state_r == ACC);

    // Saturating count of active cycles, restarted for every accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles_r <= 16'h0000;
        end else if (start_accept_s) begin
            perf_cycles_r <= 16'h0000;
        end else if (perf_active_s && (perf_cycles_r != 16'hFFFF)) begin
            perf_cycles_r <= perf_cycles_r + 16'h0001;
        end else begin
            perf_cycles_r <= perf_cycles_r;
        end
    end

    assign perf_cycles = perf_cycles_r;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mac_seq_ctrl
//   Directed testbench for mac_seq_ctrl (N_TERMS=4). The expected output
//   vectors are hand-derived from the cycle schedule: start at cycle 0, then
//   each term takes 6 cycles (WAIT_OP, MUL0..3, ACC), and DONE falls at cycle 25.
// ---------------------------------------------------------------------------
module tb_mac_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic       out_ready;
    logic       out_valid;
    logic       busy;
    logic       ld_in;
    logic       prod_clr;
    logic       prod_ld;
    logic       sela;
    logic       selb;
    logic       psh;
    logic       acc_clr;
    logic       acc_ld;
    logic [2:0] term_cnt;
`ifdef MAC_SEQ_CTRL_PERF_EN
    logic [15:0] perf_cycles;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Packed output vector:
    // {in_ready,out_valid,busy,ld_in,prod_clr,prod_ld,sela,selb,psh,acc_clr,acc_ld}
    logic [10:0] outs;
    assign outs = {in_ready, out_valid, busy, ld_in, prod_clr, prod_ld,
                   sela, selb, psh, acc_clr, acc_ld};

    localparam logic [10:0] V_ZERO    = 11'b000_0000_0000;
    localparam logic [10:0] V_START   = 11'b000_0000_0010;
    localparam logic [10:0] V_WAIT_HS = 11'b101_1100_0000;
    localparam logic [10:0] V_WAIT    = 11'b101_0000_0000;
    localparam logic [10:0] V_MUL0    = 11'b001_0011_1000;
    localparam logic [10:0] V_MUL1    = 11'b001_0011_0100;
    localparam logic [10:0] V_MUL2    = 11'b001_0010_1000;
    localparam logic [10:0] V_MUL3    = 11'b001_0010_0100;
    localparam logic [10:0] V_ACC     = 11'b001_0000_0001;
    localparam logic [10:0] V_DONE    = 11'b011_0000_0000;

    mac_seq_ctrl #(.N_TERMS(4), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .busy      (busy),
        .ld_in     (ld_in),
        .prod_clr  (prod_clr),
        .prod_ld   (prod_ld),
        .sela      (sela),
        .selb      (selb),
        .psh       (psh),
        .acc_clr   (acc_clr),
        .acc_ld    (acc_ld),
        .term_cnt  (term_cnt)
`ifdef MAC_SEQ_CTRL_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Counts one comparison and reports a mismatch.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Hand-derived schedule for a run with start at cycle 0, in_valid and
    // out_ready held high.
    function automatic logic [10:0] exp_outs(input int c);
        logic [10:0] v;
        if (c == 0) begin
            v = V_START;
        end else if (c >= 1 && c <= 24) begin
            case ((c - 1) % 6)
                0:       v = V_WAIT_HS;
                1:       v = V_MUL0;
                2:       v = V_MUL1;
                3:       v = V_MUL2;
                4:       v = V_MUL3;
                default: v = V_ACC;
            endcase
        end else if (c == 25) begin
            v = V_DONE;
        end else begin
            v = V_ZERO;
        end
        return v;
    endfunction

    function automatic logic [2:0] exp_cnt(input int c);
        logic [2:0] n;
        if (c >= 1 && c <= 24) begin
            n = 3'((c - 1) / 6);
        end else if (c == 25) begin
            n = 3'd4;
        end else begin
            n = 3'd0;
        end
        return n;
    endfunction

    // One complete MAC operation from IDLE. With pulse_start set, start is
    // also pulsed in MUL1 (cycle 3) and ACC (cycle 6) and must be ignored.
    task automatic full_run(input string tag, input bit pulse_start);
        for (int c = 0; c < 28; c++) begin
            start     = (c == 0) || (pulse_start && (c == 3 || c == 6));
            in_valid  = 1'b1;
            out_ready = 1'b1;
            #2;
            chk({tag, "_outs"}, 32'(outs), 32'(exp_outs(c)));
            chk({tag, "_cnt"},  32'(term_cnt), 32'(exp_cnt(c)));
`ifdef MAC_SEQ_CTRL_PERF_EN
            if (c == 25) begin
                chk({tag, "_perf"}, 32'(perf_cycles), 32'd24);
            end
`endif
            next_cyc();
        end
        start = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Reset for two cycles, then five idle cycles.
        next_cyc();
        next_cyc();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("rst_idle_outs", 32'(outs), 32'(V_ZERO));
            chk("rst_idle_cnt", 32'(term_cnt), 32'd0);
            next_cyc();
        end

        // Nominal operation.
        full_run("run", 1'b0);

        // Reset during MUL2 of the second term (cycle 10).
        for (int c = 0; c <= 10; c++) begin
            start    = (c == 0);
            in_valid = 1'b1;
            rst      = (c == 10);
            #2;
            if (c == 10) begin
                chk("midrst_pre_outs", 32'(busy & prod_ld & selb & ~sela & ~psh), 32'd1);
                chk("midrst_pre_cnt", 32'(term_cnt), 32'd1);
            end
            next_cyc();
        end
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        #2;
        chk("midrst_outs", 32'(outs), 32'(V_ZERO));
        chk("midrst_cnt", 32'(term_cnt), 32'd0);
        next_cyc();
        full_run("after_rst", 1'b0);

        // start pulses outside IDLE must not disturb the sequence.
        full_run("ign_start", 1'b1);

        // Back-pressure on both handshakes.
        for (int c = 0; c <= 34; c++) begin
            start     = (c == 0);
            in_valid  = !(c >= 7 && c <= 9);
            out_ready = !(c >= 28 && c <= 31);
            #2;
            if (c >= 7 && c <= 9) begin
                chk("bp_in_outs", 32'(outs), 32'(V_WAIT));
                chk("bp_in_cnt", 32'(term_cnt), 32'd1);
            end else if (c == 10) begin
                chk("bp_in_resume", 32'(outs), 32'(V_WAIT_HS));
            end else if (c == 27) begin
                chk("bp_last_acc", 32'(outs), 32'(V_ACC));
            end else if (c >= 28 && c <= 32) begin
                chk("bp_out_outs", 32'(outs), 32'(V_DONE));
                chk("bp_out_cnt", 32'(term_cnt), 32'd4);
            end else if (c == 33) begin
                chk("bp_out_idle", 32'(outs), 32'(V_ZERO));
                chk("bp_out_idle_cnt", 32'(term_cnt), 32'd0);
            end
            next_cyc();
        end
        start     = 1'b0;
        out_ready = 1'b1;

        // start together with rst: the controller stays in IDLE.
        rst   = 1'b1;
        start = 1'b1;
        next_cyc();
        rst   = 1'b0;
        start = 1'b0;
        in_valid = 1'b1;
        #2;
        chk("rst_start_outs", 32'(outs), 32'(V_ZERO));
        chk("rst_start_cnt", 32'(term_cnt), 32'd0);
        next_cyc();
        #2;
        chk("rst_start_hold", 32'(outs), 32'(V_ZERO));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
